// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: pipelined FP32 pairwise adder tree; define ADDER_TREE_ACC_EN for the group accumulator stage
module fp_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mode,
    input  logic [1:0]  rmode,
    output logic [31:0] y
);
    logic        sb, swap, eff_sub, sgn, a_nan, b_nan, a_inf, b_inf, rnd_up;
    logic [31:0] x, z;
    logic [7:0]  ex, ez, d;
    logic [4:0]  sh_r, sh_l, lz;
    logic [26:0] mx, mz, mz_sh, norm;
    logic [53:0] al;
    logic [27:0] sum;
    logic [9:0]  er, ef;
    logic [24:0] mr;
    always_comb begin
        sb      = b[31] ^ mode;
        a_nan   = &a[30:23] && |a[22:0];
        b_nan   = &b[30:23] && |b[22:0];
        a_inf   = &a[30:23] && ~|a[22:0];
        b_inf   = &b[30:23] && ~|b[22:0];
        swap    = b[30:0] > a[30:0];
        x       = swap ? {sb, b[30:0]} : a;
        z       = swap ? a : {sb, b[30:0]};
        sgn     = x[31];
        eff_sub = x[31] ^ z[31];
        ex      = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ez      = (z[30:23] == 8'd0) ? 8'd1 : z[30:23];
        mx      = {|x[30:23], x[22:0], 3'b0};
        mz      = {|z[30:23], z[22:0], 3'b0};
        d       = ex - ez;
        sh_r    = (d > 8'd27) ? 5'd27 : d[4:0];
        al      = {mz, 27'b0} >> sh_r;
        mz_sh   = al[53:27] | {26'b0, |al[26:0]};
        sum     = eff_sub ? {1'b0, mx} - {1'b0, mz_sh} : {1'b0, mx} + {1'b0, mz_sh};
        lz      = 5'd27;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);
        // left shift stops at the minimum exponent so tiny results land as denormals
        sh_l    = ({3'b0, lz} < ex) ? lz : 5'(ex - 8'd1);
        norm    = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0] << sh_l;
        er      = sum[27] ? {2'b0, ex} + 10'd1 : {2'b0, ex} - {5'b0, sh_l};
        rnd_up  = (rmode == 2'd0) ? norm[2] & (norm[1] | norm[0] | norm[3]) :
                  (rmode == 2'd2) ? !sgn && |norm[2:0] :
                  (rmode == 2'd3) ? sgn && |norm[2:0] : 1'b0;
        mr      = {1'b0, norm[26:3]} + 25'(rnd_up);
        ef      = mr[24] ? er + 10'd1 : (mr[23] ? er : 10'd0);
        y       = {sgn, ef[7:0], mr[22:0]};
        if (ef >= 10'd255)
            y = (rmode == 2'd1 || (rmode == 2'd2 && sgn) || (rmode == 2'd3 && !sgn)) ?
                {sgn, 8'hFE, 23'h7FFFFF} : {sgn, 8'hFF, 23'h0};
        if (sum == 28'd0)
            y = {eff_sub ? (rmode == 2'd3) : sgn, 31'h0};
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != sb)))
            y = 32'h7FC00000;
        else if (a_inf)
            y = {a[31], 8'hFF, 23'h0};
        else if (b_inf)
            y = {sb, 8'hFF, 23'h0};
    end
endmodule

module adder_tree_pipe #(
    parameter int N_IN = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [32*N_IN-1:0] Data_In,
    input  logic [1:0]        RMode,
    input  logic              Valid_In,
    output logic              Ready_Out,
    input  logic              Last_In,
    output logic [31:0]       Data_Out,
    output logic              Valid_Out,
    input  logic              Ready_In
);
    localparam int LVL = $clog2(N_IN);

    assign Ready_Out = !(Valid_Out && !Ready_In);

    genvar l, k;
    generate
        for (l = 0; l <= LVL; l++) begin : lv
            localparam int W = N_IN >> l;
            logic [32*W-1:0] q;
            logic            v;
            logic [1:0]      rm;
            if (l == 0) begin : g_in
                assign q  = Data_In;
                assign v  = Valid_In && Ready_Out;
                assign rm = RMode;
            end else begin : g_st
                logic [32*W-1:0] s;
                for (k = 0; k < W; k++) begin : add
                    fp_adder u_add (
                        .a(lv[l-1].q[64*k +: 32]),
                        .b(lv[l-1].q[64*k+32 +: 32]),
                        .mode(1'b0),
                        .rmode(lv[l-1].rm),
                        .y(s[32*k +: 32])
                    );
                end
                always_ff @(posedge Clk or posedge Rst)
                    if (Rst) begin
                        q  <= '0;
                        v  <= 1'b0;
                        rm <= 2'd0;
                    end else if (Ready_Out) begin
                        q  <= s;
                        v  <= lv[l-1].v;
                        rm <= lv[l-1].rm;
                    end
            end
        end
    endgenerate

`ifdef ADDER_TREE_ACC_EN
    logic [LVL-1:0] last_sr;
    logic [31:0]    acc, acc_sum, data_q;
    logic           acc_act, valid_q, last_t;

    assign last_t = last_sr[LVL-1];

    fp_adder u_acc (
        .a(acc_act ? acc : 32'h0),
        .b(lv[LVL].q),
        .mode(1'b0),
        .rmode(lv[LVL].rm),
        .y(acc_sum)
    );

    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            last_sr <= '0;
            acc     <= 32'h0;
            acc_act <= 1'b0;
            data_q  <= 32'h0;
            valid_q <= 1'b0;
        end else if (Ready_Out) begin
            last_sr <= (last_sr << 1) | LVL'(Last_In);
            valid_q <= lv[LVL].v && last_t;
            if (lv[LVL].v) begin
                acc     <= last_t ? 32'h0 : acc_sum;
                acc_act <= !last_t;
                if (last_t) data_q <= acc_sum;
            end
        end

    assign Data_Out  = data_q;
    assign Valid_Out = valid_q;
`else
    logic [2:0] unused_bits;
    assign unused_bits = {Last_In, lv[LVL].rm};
    assign Data_Out    = lv[LVL].q;
    assign Valid_Out   = lv[LVL].v;
`endif
endmodule

// File: doc/adder_tree_pipe.md
ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

Interface
REQ-001 SHALL have parameter N_IN, default 16, number of FP32 operands per beat; power of two, 2..64.
REQ-002 SHALL have derived localparam LVL = log2(N_IN), the number of tree levels.
REQ-003 SHALL have port Clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port Rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Data_In  input  32*N_IN  packed IEEE-754 single operands; operand k at bits [32k+31:32k].
REQ-006 SHALL have port RMode  input  2  rounding mode, sampled with the beat and forwarded to every FP_Adder of that beat.
REQ-007 SHALL have port Valid_In  input  1  upstream beat valid.
REQ-008 SHALL have port Ready_Out  output  1  block can accept a beat this cycle.
REQ-009 SHALL have port Last_In  input  1  final beat of an accumulation group; ignored unless ADDER_TREE_ACC_EN.
REQ-010 SHALL have port Data_Out  output  32  FP32 sum.
REQ-011 SHALL have port Valid_Out  output  1  Data_Out valid.
REQ-012 SHALL have port Ready_In  input  1  downstream accepts Data_Out.

Function
REQ-013 SHALL reduce operands pairwise: level L adds adjacent results of level L-1 via combinational FP_Adder instances (Mode=0 add, RMode from beat).
REQ-014 SHALL register every level output, together with its valid bit and RMode, giving LVL pipeline stages.
REQ-015 SHALL accept a beat when Valid_In && Ready_Out.
REQ-016 SHALL drive Ready_Out = !(Valid_Out && !Ready_In); stall is global.
REQ-017 SHALL freeze all pipeline registers (data, valid, RMode) during stall; Data_Out and Valid_Out SHALL stay stable until taken.
REQ-018 SHALL sustain one beat per cycle when Ready_In stays high; no bubbles inserted.
REQ-019 SHALL have latency LVL cycles from acceptance to Valid_Out when not stalled (accumulation disabled).
REQ-020 SHALL preserve beat order; no beat dropped or duplicated under any Ready_In pattern.
REQ-021 SHALL leave NaN, infinity, denormal and rounding semantics to FP_Adder; no extra handling here.
REQ-022 SHALL insert bubbles (valid 0) into stage 1 when no beat is accepted; bubble contents are don't-care.

Reset
REQ-023 SHALL on Rst clear all stage valid bits, Valid_Out=0, Data_Out=32'h0, accumulator=32'h0, accumulator-active flag=0, immediately and asynchronously.
REQ-024 SHALL drive Ready_Out=1 while and after reset.
REQ-025 SHALL discard in-flight beats and partial accumulations on reset mid-operation; no Valid_Out for them afterwards.

Configuration
REQ-026 SHALL support macro ADDER_TREE_ACC_EN.
REQ-027 With ADDER_TREE_ACC_EN defined: one extra stage adds each tree result into a 32-bit accumulator, seeded with +0.0 (32'h0) at group start; Last_In travels with the beat.
REQ-028 With ADDER_TREE_ACC_EN defined: Valid_Out asserts only for the beat carrying Last_In, Data_Out = group total, latency LVL+1; accumulator re-seeds to +0.0 afterwards; stall also freezes the accumulator.
REQ-029 With ADDER_TREE_ACC_EN defined: a group of one beat (Last_In on first beat) outputs that beat's tree sum.
REQ-030 Without ADDER_TREE_ACC_EN: no accumulator logic, Last_In unused, every beat produces one output after LVL cycles.

Verification
REQ-031 SHALL verify N_IN=16, all operands 32'h3F800000 (1.0) -> Data_Out 32'h41800000 (16.0), Valid_Out exactly 4 cycles after acceptance.
REQ-032 SHALL verify N_IN=2, operands 32'h3FC00000 (1.5) and 32'h40200000 (2.5) -> 32'h40800000 (4.0) after 1 cycle.
REQ-033 SHALL verify 5 back-to-back beats of sums 1.0..5.0, Ready_In held low 3 cycles mid-stream -> Ready_Out low during stall, Data_Out stable, all 5 results in order, no loss.
REQ-034 SHALL verify Rst asserted with 3 beats in flight -> Valid_Out=0 and Data_Out=32'h0 immediately; none of the 3 results appear.
REQ-035 SHALL verify, with ADDER_TREE_ACC_EN and N_IN=16: 3 beats of all 1.0, Last_In on third -> single Valid_Out with 32'h42400000 (48.0) at LVL+1 cycles after third beat.
REQ-036 SHALL verify, with ADDER_TREE_ACC_EN: a second group immediately following the first restarts at +0.0 (1 beat of all 1.0, Last_In -> 32'h41800000).
